// File: rtl/instruction_memory_sync.sv
// Instruction memory with a synchronous fetch port and a loader write port.
// After reset the array is filled with NOP_INS, one word per cycle, before
// any loads or fetches are accepted. Fetches return one cycle after
// acceptance; misaligned or out-of-range fetches return NOP_INS with a fault.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready never depends on req_valid. Once rsp_valid is high,
// rsp_valid, rsp_instr and rsp_fault hold until rsp_ready is seen high.
module instruction_memory_sync #(
    parameter int INS_ADDRESS = 32,
    parameter int INS_W       = 32,
    parameter int DEPTH       = 64,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(32'h00000013)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INS_W-1:0]         load_data,
    output logic                     load_ready,
    input  logic                     req_valid,
    input  logic [INS_ADDRESS-1:0]   req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INS_W-1:0]         rsp_instr,
    output logic                     rsp_fault,
    output logic                     state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int BO = $clog2(INS_W / 8);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]             state;
    logic [AW-1:0]          clr_cnt;
    logic [INS_W-1:0]       mem [DEPTH];

    logic [INS_ADDRESS-1:0] word_idx;
    logic [AW-1:0]          rd_idx;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   fault;
    logic                   accept;

    // Address decode: word index, alignment and range checks.
    assign word_idx     = req_addr >> BO;
    assign rd_idx       = word_idx[AW-1:0];
    // Any bit at or above AW in the full-width word index is out of range.
    assign out_of_range = |(word_idx >> AW);

    generate
        if (BO == 0) begin : g_byte_words
            assign misaligned = 1'b0;
        end else begin : g_multi_byte_words
            assign misaligned = |req_addr[BO-1:0];
        end
    endgenerate

    assign fault      = misaligned | out_of_range;
    assign load_ready = (state == ST_RUN);
    // Loader writes win over fetches, so a cycle never both reads and writes.
    assign req_ready  = (state == ST_RUN) && !load_en && (!rsp_valid || rsp_ready);
    assign accept     = req_valid && req_ready;
    assign state_dbg  = state;

    // Clear sequencer: walk every index once, then run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == AW'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Memory write port: NOP fill while clearing, loader writes while running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= NOP_INS;
            end else if (load_en) begin
                mem[load_addr] <= load_data;
            end
        end
    end

    // Response register: load on accept, drop on consume, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_instr <= NOP_INS;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
            rsp_instr <= fault ? NOP_INS : mem[rd_idx];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
